bp_tournament_updater: RTL and testbench

Training/write side of the tournament (local/global/choice) branch predictor. Resolved branches from the branch unit carry the counters and history snapshots read at prediction time. The block computes new saturating-counter and history values and drives the write ports of the local history table (LHT), the local, global and choice counter tables. It also keeps the committed global history used by the frontend to repair its speculative history after a flush. After reset it sweeps every table to its initial value before it accepts updates.

---
 rtl/bp_tournament_updater.sv | 194 +++++++++++++++++++
 tb/tb_bp_tournament_updater.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_tournament_updater.sv
// Tournament branch predictor training path: after reset it sweeps every predictor
// table to its initial value, then turns resolved branches into table write beats.
module bp_tournament_updater #(
  parameter int LocalHistoryTableIndexBits = 10,
  parameter int LocalPredictorIndexBits    = 10,
  parameter int GlobalPredictorIndexBits   = 10,
  parameter int ChoicePredictorIndexBits   = 10,
  parameter int LocalCtrBits               = 2,
  parameter int GlobalCtrBits              = 2,
  parameter int ChoiceCtrBits              = 2,
  parameter int VLEN                       = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  upd_valid_i,
  output logic                                  upd_ready_o,
  input  logic [VLEN-1:0]                       upd_pc_i,
  input  logic                                  upd_taken_i,
  input  logic [GlobalPredictorIndexBits-1:0]   upd_ghr_i,
  input  logic [LocalPredictorIndexBits-1:0]    upd_lhist_i,
  input  logic [LocalCtrBits-1:0]               upd_local_ctr_i,
  input  logic [GlobalCtrBits-1:0]              upd_global_ctr_i,
  input  logic [ChoiceCtrBits-1:0]              upd_choice_ctr_i,
  output logic                                  wr_valid_o,
  input  logic                                  wr_ready_i,
  output logic                                  wr_lht_en_o,
  output logic                                  wr_local_en_o,
  output logic                                  wr_global_en_o,
  output logic                                  wr_choice_en_o,
  output logic [LocalHistoryTableIndexBits-1:0] wr_lht_idx_o,
  output logic [LocalPredictorIndexBits-1:0]    wr_lht_data_o,
  output logic [LocalPredictorIndexBits-1:0]    wr_local_idx_o,
  output logic [LocalCtrBits-1:0]               wr_local_data_o,
  output logic [GlobalPredictorIndexBits-1:0]   wr_global_idx_o,
  output logic [GlobalCtrBits-1:0]              wr_global_data_o,
  output logic [ChoicePredictorIndexBits-1:0]   wr_choice_idx_o,
  output logic [ChoiceCtrBits-1:0]              wr_choice_data_o,
  output logic [GlobalPredictorIndexBits-1:0]   commit_ghr_o,
  output logic                                  init_done_o
);

  localparam int LhtB = LocalHistoryTableIndexBits;
  localparam int LocB = LocalPredictorIndexBits;
  localparam int GlbB = GlobalPredictorIndexBits;
  localparam int ChoB = ChoicePredictorIndexBits;
  localparam int MaxA = (LhtB > LocB) ? LhtB : LocB;
  localparam int MaxB = (GlbB > ChoB) ? GlbB : ChoB;
  localparam int SweepBits = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int PcHi = (LhtB > GlbB) ? LhtB : GlbB;

  localparam logic [LocalCtrBits-1:0]  LocalInit  = LocalCtrBits'((1 << (LocalCtrBits - 1)) - 1);
  localparam logic [GlobalCtrBits-1:0] GlobalInit = GlobalCtrBits'((1 << (GlobalCtrBits - 1)) - 1);
  localparam logic [ChoiceCtrBits-1:0] ChoiceInit = ChoiceCtrBits'((1 << (ChoiceCtrBits - 1)) - 1);
  localparam logic [LocalCtrBits-1:0]  LocalMax   = '1;
  localparam logic [GlobalCtrBits-1:0] GlobalMax  = '1;
  localparam logic [ChoiceCtrBits-1:0] ChoiceMax  = '1;
  localparam logic [LocalCtrBits-1:0]  LocalOne   = LocalCtrBits'(1);
  localparam logic [GlobalCtrBits-1:0] GlobalOne  = GlobalCtrBits'(1);
  localparam logic [ChoiceCtrBits-1:0] ChoiceOne  = ChoiceCtrBits'(1);
  localparam int LhtSize    = 1 << LhtB;
  localparam int LocalSize  = 1 << LocB;
  localparam int GlobalSize = 1 << GlbB;
  localparam int ChoiceSize = 1 << ChoB;

  typedef enum logic {S_INIT, S_RUN} state_e;

  // Only pc[PcHi:1] is ever used to index a table, so that is all the FIFO keeps.
  typedef struct packed {
    logic [PcHi-1:0]          pc;
    logic                     taken;
    logic [GlbB-1:0]          ghr;
    logic [LocB-1:0]          lhist;
    logic [LocalCtrBits-1:0]  lctr;
    logic [GlobalCtrBits-1:0] gctr;
    logic [ChoiceCtrBits-1:0] cctr;
  } upd_t;

  state_e               state_q;
  logic [SweepBits-1:0] sweep_q;
  logic                 init_done_q;
  logic [GlbB-1:0]      ghr_q, ghr_d;
  upd_t                 fifo_q [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;

  upd_t upd_in;
  upd_t head;
  logic push, pop;
  logic lp, gp;
  logic unused_pc;

  assign unused_pc = ^{upd_pc_i[VLEN-1:PcHi+1], upd_pc_i[0]};

  assign upd_in = '{pc:    upd_pc_i[PcHi:1],
                    taken: upd_taken_i,
                    ghr:   upd_ghr_i,
                    lhist: upd_lhist_i,
                    lctr:  upd_local_ctr_i,
                    gctr:  upd_global_ctr_i,
                    cctr:  upd_choice_ctr_i};

  assign head        = fifo_q[rd_ptr_q];
  assign lp          = head.lctr[LocalCtrBits-1];
  assign gp          = head.gctr[GlobalCtrBits-1];
  assign upd_ready_o = (state_q == S_RUN) && (count_q != 2'd2);
  assign wr_valid_o  = (state_q == S_INIT) || (count_q != 2'd0);
  assign push        = upd_valid_i && upd_ready_o;
  assign pop         = (state_q == S_RUN) && (count_q != 2'd0) && wr_ready_i;
  assign commit_ghr_o = ghr_q;
  assign init_done_o  = init_done_q;

  always_comb begin
    wr_lht_en_o    = 1'b1;
    wr_local_en_o  = 1'b1;
    wr_global_en_o = 1'b1;
    wr_choice_en_o = (lp != gp);
    wr_lht_idx_o   = head.pc[LhtB-1:0];
    wr_lht_data_o  = {head.lhist[LocB-2:0], head.taken};
    wr_local_idx_o = head.lhist;
    wr_global_idx_o = head.ghr ^ head.pc[GlbB-1:0];
    wr_choice_idx_o = head.ghr[ChoB-1:0];
    if (head.taken) begin
      wr_local_data_o  = (head.lctr == LocalMax)  ? head.lctr : head.lctr + LocalOne;
      wr_global_data_o = (head.gctr == GlobalMax) ? head.gctr : head.gctr + GlobalOne;
    end else begin
      wr_local_data_o  = (head.lctr == '0) ? head.lctr : head.lctr - LocalOne;
      wr_global_data_o = (head.gctr == '0) ? head.gctr : head.gctr - GlobalOne;
    end
    // The chooser moves toward the global predictor whenever it was the one that was right.
    if (gp == head.taken) begin
      wr_choice_data_o = (head.cctr == ChoiceMax) ? head.cctr : head.cctr + ChoiceOne;
    end else begin
      wr_choice_data_o = (head.cctr == '0) ? head.cctr : head.cctr - ChoiceOne;
    end
    if (state_q == S_INIT) begin
      wr_lht_en_o      = int'(sweep_q) < LhtSize;
      wr_local_en_o    = int'(sweep_q) < LocalSize;
      wr_global_en_o   = int'(sweep_q) < GlobalSize;
      wr_choice_en_o   = int'(sweep_q) < ChoiceSize;
      wr_lht_idx_o     = sweep_q[LhtB-1:0];
      wr_local_idx_o   = sweep_q[LocB-1:0];
      wr_global_idx_o  = sweep_q[GlbB-1:0];
      wr_choice_idx_o  = sweep_q[ChoB-1:0];
      wr_lht_data_o    = '0;
      wr_local_data_o  = LocalInit;
      wr_global_data_o = GlobalInit;
      wr_choice_data_o = ChoiceInit;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    ghr_d = pop ? {ghr_q[GlbB-2:0], head.taken} : ghr_q;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= upd_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      ghr_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ghr_q    <= ghr_d;
      if (state_q == S_INIT && wr_ready_i) begin
        sweep_q <= sweep_q + SweepBits'(1);
        if (sweep_q == '1) begin
          state_q     <= S_RUN;
          init_done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_tournament_updater.sv
// Self-checking bench for bp_tournament_updater: table sweep, directed training cases,
// backpressure, randomized traffic against a queue-based model, and mid-run reset.
module tb_bp_tournament_updater;

  typedef struct packed {
    logic [63:0] pc;
    logic        taken;
    logic [9:0]  ghr;
    logic [9:0]  lhist;
    logic [1:0]  lc;
    logic [1:0]  gc;
    logic [1:0]  cc;
  } upd_s;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [63:0] upd_pc_i;
  logic        upd_taken_i;
  logic [9:0]  upd_ghr_i;
  logic [9:0]  upd_lhist_i;
  logic [1:0]  upd_local_ctr_i, upd_global_ctr_i, upd_choice_ctr_i;
  logic        wr_valid_o;
  logic        wr_ready_i;
  logic        wr_lht_en_o, wr_local_en_o, wr_global_en_o, wr_choice_en_o;
  logic [9:0]  wr_lht_idx_o, wr_lht_data_o, wr_local_idx_o, wr_global_idx_o, wr_choice_idx_o;
  logic [1:0]  wr_local_data_o, wr_global_data_o, wr_choice_data_o;
  logic [9:0]  commit_ghr_o;
  logic        init_done_o;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   expGhr = 0;
  upd_s modelQ[$];

  bp_tournament_updater dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_ghr_i(upd_ghr_i), .upd_lhist_i(upd_lhist_i),
    .upd_local_ctr_i(upd_local_ctr_i), .upd_global_ctr_i(upd_global_ctr_i),
    .upd_choice_ctr_i(upd_choice_ctr_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .wr_lht_en_o(wr_lht_en_o), .wr_local_en_o(wr_local_en_o),
    .wr_global_en_o(wr_global_en_o), .wr_choice_en_o(wr_choice_en_o),
    .wr_lht_idx_o(wr_lht_idx_o), .wr_lht_data_o(wr_lht_data_o),
    .wr_local_idx_o(wr_local_idx_o), .wr_local_data_o(wr_local_data_o),
    .wr_global_idx_o(wr_global_idx_o), .wr_global_data_o(wr_global_data_o),
    .wr_choice_idx_o(wr_choice_idx_o), .wr_choice_data_o(wr_choice_data_o),
    .commit_ghr_o(commit_ghr_o), .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Choice data only matters when the choice table is actually written.
  function automatic logic [59:0] observedBeat();
    return {wr_lht_en_o, wr_local_en_o, wr_global_en_o, wr_choice_en_o,
            wr_lht_idx_o, wr_lht_data_o, wr_local_idx_o, wr_local_data_o,
            wr_global_idx_o, wr_global_data_o, wr_choice_idx_o,
            wr_choice_en_o ? wr_choice_data_o : 2'd0};
  endfunction

  function automatic logic [59:0] modelBeat(input upd_s u);
    int  pcIdx = int'((u.pc >> 1) & 64'h3FF);
    int  t     = int'(u.taken);
    int  lc    = int'(u.lc);
    int  gc    = int'(u.gc);
    int  cc    = int'(u.cc);
    int  lNew  = (t == 1) ? ((lc < 3) ? lc + 1 : 3) : ((lc > 0) ? lc - 1 : 0);
    int  gNew  = (t == 1) ? ((gc < 3) ? gc + 1 : 3) : ((gc > 0) ? gc - 1 : 0);
    int  gpT   = (gc >= 2) ? 1 : 0;
    bit  chEn  = (lc >= 2) != (gc >= 2);
    int  cNew  = (gpT == t) ? ((cc < 3) ? cc + 1 : 3) : ((cc > 0) ? cc - 1 : 0);
    return {3'b111, chEn, 10'(pcIdx), 10'((int'(u.lhist) * 2 + t) % 1024), u.lhist, 2'(lNew),
            u.ghr ^ 10'(pcIdx), 2'(gNew), u.ghr, chEn ? 2'(cNew) : 2'd0};
  endfunction

  function automatic upd_s mk(input logic [63:0] pc, input logic taken, input logic [9:0] ghr,
                              input logic [9:0] lhist, input logic [1:0] lc, input logic [1:0] gc,
                              input logic [1:0] cc);
    upd_s u;
    u.pc = pc; u.taken = taken; u.ghr = ghr; u.lhist = lhist;
    u.lc = lc; u.gc = gc; u.cc = cc;
    return u;
  endfunction

  function automatic upd_s randomUpd();
    return mk({$urandom, $urandom}, 1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
              2'($urandom), 2'($urandom), 2'($urandom));
  endfunction

  task automatic drive(input upd_s u);
    upd_pc_i = u.pc; upd_taken_i = u.taken; upd_ghr_i = u.ghr; upd_lhist_i = u.lhist;
    upd_local_ctr_i = u.lc; upd_global_ctr_i = u.gc; upd_choice_ctr_i = u.cc;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; upd_valid_i = 1'b0; wr_ready_i = 1'b0;
    drive(mk(64'd0, 1'b0, 10'd0, 10'd0, 2'd0, 2'd0, 2'd0));
    repeat (3) @(negedge clk_i);
    testsRun++;
    if ({upd_ready_o, wr_valid_o, init_done_o} !== 3'b010) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got ready/valid/done=%b required 010",
               {upd_ready_o, wr_valid_o, init_done_o});
    end
    testsRun++;
    if (observedBeat() !== {4'b1111, 10'd0, 10'd0, 10'd0, 2'd1, 10'd0, 2'd1, 10'd0, 2'd1}) begin
      testsFailed++;
      $display("[TB] FAIL reset_beat: got %h required %h", observedBeat(),
               {4'b1111, 10'd0, 10'd0, 10'd0, 2'd1, 10'd0, 2'd1, 10'd0, 2'd1});
    end
    testsRun++;
    if (commit_ghr_o !== 10'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ghr: got %h required 000", commit_ghr_o);
    end
    rst_i = 1'b0;
    expGhr = 0;
  endtask

  task automatic test_init_sweep(input bit stall);
    int beat = 0;
    bit done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (beat < 1024) begin
        testsRun++;
        if ({wr_valid_o, upd_ready_o, init_done_o, observedBeat()} !==
            {3'b100, 4'b1111, 10'(beat), 10'd0, 10'(beat), 2'd1, 10'(beat), 2'd1, 10'(beat), 2'd1}) begin
          testsFailed++;
          $display("[TB] FAIL init_beat %0d: got v/r/d=%b beat=%h required 100 beat=%h", beat,
                   {wr_valid_o, upd_ready_o, init_done_o}, observedBeat(),
                   {4'b1111, 10'(beat), 10'd0, 10'(beat), 2'd1, 10'(beat), 2'd1, 10'(beat), 2'd1});
        end
        wr_ready_i = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (wr_ready_i) beat++;
        @(negedge clk_i);
      end else begin
        done = 1'b1;
        testsRun++;
        if ({init_done_o, upd_ready_o, wr_valid_o} !== 3'b110) begin
          testsFailed++;
          $display("[TB] FAIL init_done: got done/ready/valid=%b required 110",
                   {init_done_o, upd_ready_o, wr_valid_o});
        end
        testsRun++;
        if (commit_ghr_o !== 10'd0) begin
          testsFailed++;
          $display("[TB] FAIL init_ghr: got %h required 000", commit_ghr_o);
        end
      end
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL init_timeout: sweep reached beat %0d, required 1024", beat);
    end
    wr_ready_i = 1'b1;
  endtask

  task automatic test_directed();
    drive(mk(64'h8000_0010, 1'b1, 10'h00F, 10'h005, 2'd1, 2'd2, 2'd0));
    upd_valid_i = 1'b1;
    testsRun++;
    if (upd_ready_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL directed_ready: got %b required 1", upd_ready_o);
    end
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    testsRun++;
    if ({wr_valid_o, observedBeat()} !==
        {1'b1, 4'b1111, 10'h008, 10'h00B, 10'h005, 2'd2, 10'h007, 2'd3, 10'h00F, 2'd1}) begin
      testsFailed++;
      $display("[TB] FAIL directed_beat: got v=%b %h required v=1 %h", wr_valid_o, observedBeat(),
               {4'b1111, 10'h008, 10'h00B, 10'h005, 2'd2, 10'h007, 2'd3, 10'h00F, 2'd1});
    end
    @(negedge clk_i);
    testsRun++;
    if ({wr_valid_o, commit_ghr_o} !== {1'b0, 10'h001}) begin
      testsFailed++;
      $display("[TB] FAIL directed_ghr: got v=%b ghr=%h required v=0 ghr=001", wr_valid_o, commit_ghr_o);
    end
    expGhr = 1;
  endtask

  task automatic test_saturation();
    upd_s        u[4];
    logic [59:0] expBeat[4];
    logic [9:0]  expG[4];
    u[0] = mk(64'h100, 1'b1, 10'h000, 10'h000, 2'd3, 2'd3, 2'd1);
    u[1] = mk(64'h200, 1'b0, 10'h3FF, 10'h3FF, 2'd0, 2'd0, 2'd2);
    u[2] = mk(64'h000, 1'b1, 10'h002, 10'h001, 2'd0, 2'd3, 2'd3);
    u[3] = mk(64'h006, 1'b1, 10'h004, 10'h200, 2'd3, 2'd0, 2'd0);
    expBeat[0] = {4'b1110, 10'h080, 10'h001, 10'h000, 2'd3, 10'h080, 2'd3, 10'h000, 2'd0};
    expBeat[1] = {4'b1110, 10'h100, 10'h3FE, 10'h3FF, 2'd0, 10'h2FF, 2'd0, 10'h3FF, 2'd0};
    expBeat[2] = {4'b1111, 10'h000, 10'h003, 10'h001, 2'd1, 10'h002, 2'd3, 10'h002, 2'd3};
    expBeat[3] = {4'b1111, 10'h003, 10'h001, 10'h200, 2'd3, 10'h007, 2'd1, 10'h004, 2'd0};
    expG[0] = 10'h003; expG[1] = 10'h006; expG[2] = 10'h00D; expG[3] = 10'h01B;
    for (int i = 0; i < 4; i++) begin
      drive(u[i]);
      upd_valid_i = 1'b1;
      @(negedge clk_i);
      upd_valid_i = 1'b0;
      testsRun++;
      if ({wr_valid_o, observedBeat()} !== {1'b1, expBeat[i]}) begin
        testsFailed++;
        $display("[TB] FAIL sat_beat %0d: got v=%b %h required v=1 %h", i, wr_valid_o,
                 observedBeat(), expBeat[i]);
      end
      @(negedge clk_i);
      testsRun++;
      if (commit_ghr_o !== expG[i]) begin
        testsFailed++;
        $display("[TB] FAIL sat_ghr %0d: got %h required %h", i, commit_ghr_o, expG[i]);
      end
    end
    expGhr = 'h1B;
  endtask

  task automatic test_backpressure();
    upd_s u1 = mk(64'h0002, 1'b1, 10'h011, 10'h022, 2'd1, 2'd1, 2'd1);
    upd_s u2 = mk(64'h0004, 1'b0, 10'h033, 10'h044, 2'd2, 2'd1, 2'd2);
    upd_s u3 = mk(64'h0006, 1'b1, 10'h055, 10'h066, 2'd0, 2'd2, 2'd3);
    wr_ready_i = 1'b0;
    drive(u1); upd_valid_i = 1'b1;
    @(negedge clk_i);
    drive(u2);
    testsRun++;
    if ({upd_ready_o, wr_valid_o, observedBeat()} !== {2'b11, modelBeat(u1)}) begin
      testsFailed++;
      $display("[TB] FAIL bp_one: got r/v=%b %h required 11 %h", {upd_ready_o, wr_valid_o},
               observedBeat(), modelBeat(u1));
    end
    @(negedge clk_i);
    drive(u3);
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if ({upd_ready_o, wr_valid_o, observedBeat()} !== {2'b01, modelBeat(u1)}) begin
        testsFailed++;
        $display("[TB] FAIL bp_full %0d: got r/v=%b %h required 01 %h", i,
                 {upd_ready_o, wr_valid_o}, observedBeat(), modelBeat(u1));
      end
      if (i < 3) @(negedge clk_i);
    end
    wr_ready_i = 1'b1;
    @(negedge clk_i);
    expGhr = (expGhr * 2 + 1) % 1024;
    testsRun++;
    if ({upd_ready_o, observedBeat(), commit_ghr_o} !== {1'b1, modelBeat(u2), 10'(expGhr)}) begin
      testsFailed++;
      $display("[TB] FAIL bp_release: got r=%b %h ghr=%h required 1 %h ghr=%h", upd_ready_o,
               observedBeat(), commit_ghr_o, modelBeat(u2), 10'(expGhr));
    end
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    expGhr = (expGhr * 2 + 0) % 1024;
    testsRun++;
    if ({upd_ready_o, wr_valid_o, observedBeat(), commit_ghr_o} !==
        {2'b11, modelBeat(u3), 10'(expGhr)}) begin
      testsFailed++;
      $display("[TB] FAIL bp_third: got r/v=%b %h ghr=%h required 11 %h ghr=%h",
               {upd_ready_o, wr_valid_o}, observedBeat(), commit_ghr_o, modelBeat(u3), 10'(expGhr));
    end
    @(negedge clk_i);
    expGhr = (expGhr * 2 + 1) % 1024;
    testsRun++;
    if ({wr_valid_o, commit_ghr_o} !== {1'b0, 10'(expGhr)}) begin
      testsFailed++;
      $display("[TB] FAIL bp_drain: got v=%b ghr=%h required v=0 ghr=%h", wr_valid_o,
               commit_ghr_o, 10'(expGhr));
    end
  endtask

  task automatic test_random();
    upd_s u;
    upd_s h;
    bit   pushing, popping;
    modelQ.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      testsRun++;
      if ({upd_ready_o, wr_valid_o} !== {modelQ.size() < 2, modelQ.size() != 0}) begin
        testsFailed++;
        $display("[TB] FAIL rand_hs cyc %0d: got r/v=%b required %b", cyc, {upd_ready_o, wr_valid_o},
                 {modelQ.size() < 2, modelQ.size() != 0});
      end
      if (modelQ.size() != 0) begin
        testsRun++;
        if (observedBeat() !== modelBeat(modelQ[0])) begin
          testsFailed++;
          $display("[TB] FAIL rand_beat cyc %0d: got %h required %h", cyc, observedBeat(),
                   modelBeat(modelQ[0]));
        end
      end
      testsRun++;
      if (commit_ghr_o !== 10'(expGhr)) begin
        testsFailed++;
        $display("[TB] FAIL rand_ghr cyc %0d: got %h required %h", cyc, commit_ghr_o, 10'(expGhr));
      end
      u = randomUpd();
      drive(u);
      upd_valid_i = ($urandom_range(0, 3) != 0);
      wr_ready_i  = ($urandom_range(0, 2) != 0);
      pushing = upd_valid_i && (modelQ.size() < 2);
      popping = wr_ready_i && (modelQ.size() != 0);
      if (popping) begin
        h = modelQ.pop_front();
        expGhr = (expGhr * 2 + int'(h.taken)) % 1024;
      end
      if (pushing) modelQ.push_back(u);
      @(negedge clk_i);
    end
    upd_valid_i = 1'b0;
    wr_ready_i  = 1'b1;
    while (modelQ.size() != 0) begin
      h = modelQ.pop_front();
      expGhr = (expGhr * 2 + int'(h.taken)) % 1024;
    end
    repeat (3) @(negedge clk_i);
    testsRun++;
    if ({wr_valid_o, commit_ghr_o} !== {1'b0, 10'(expGhr)}) begin
      testsFailed++;
      $display("[TB] FAIL rand_drain: got v=%b ghr=%h required v=0 ghr=%h", wr_valid_o,
               commit_ghr_o, 10'(expGhr));
    end
  endtask

  task automatic test_reset_mid();
    wr_ready_i = 1'b0;
    drive(mk(64'h0ABC, 1'b1, 10'h123, 10'h321, 2'd2, 2'd1, 2'd2));
    upd_valid_i = 1'b1;
    @(negedge clk_i);
    drive(mk(64'h0DEF, 1'b1, 10'h2AA, 10'h155, 2'd1, 2'd3, 2'd0));
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    testsRun++;
    if ({upd_ready_o, wr_valid_o} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL mid_full: got r/v=%b required 01", {upd_ready_o, wr_valid_o});
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    testsRun++;
    if ({upd_ready_o, wr_valid_o, init_done_o, commit_ghr_o, observedBeat()} !==
        {3'b010, 10'd0, 4'b1111, 10'd0, 10'd0, 10'd0, 2'd1, 10'd0, 2'd1, 10'd0, 2'd1}) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: got r/v/d=%b ghr=%h beat=%h required 010 ghr=000 beat=%h",
               {upd_ready_o, wr_valid_o, init_done_o}, commit_ghr_o, observedBeat(),
               {4'b1111, 10'd0, 10'd0, 10'd0, 2'd1, 10'd0, 2'd1, 10'd0, 2'd1});
    end
    rst_i = 1'b0;
    expGhr = 0;
    test_init_sweep(1'b1);
  endtask

  initial begin
    test_reset();
    test_init_sweep(1'b0);
    test_directed();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
